// File: rtl/iddr_deser_pkg.sv
// Shared helpers for the DDR input deserialiser.
package iddr_deser_pkg;

    // Bits needed to hold values 0..value-1, never less than one.
    function automatic int clog2_min1(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) w++;
        return w;
    endfunction

endpackage

// File: rtl/iddr_deser_lane.sv
// One DDR lane: edge capture, bit history and word-select output register.
module iddr_deser_lane #(
    parameter int RATIO = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    input  logic             d,
    input  logic             shift,
    input  logic             load,
    input  logic             odd,
    output logic [RATIO-1:0] q
);

    logic           r_q;
    logic           f_q;
    logic [RATIO:0] h;
    logic [RATIO:0] h_nxt;

    // Newest pair enters at the top; r was captured before f.
    assign h_nxt = {f_q, r_q, h[RATIO:2]};

    // Rising-edge capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_q <= 1'b0;
        else if (ce) r_q <= d;
    end

    // Falling-edge capture.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) f_q <= 1'b0;
        else if (ce) f_q <= d;
    end

    // History shift and word load; odd alignment takes the word one bit older.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h <= '0;
            q <= '0;
        end else begin
            if (shift) h <= h_nxt;
            if (load) q <= odd ? h_nxt[RATIO-1:0] : h_nxt[RATIO:1];
        end
    end

endmodule

// File: rtl/iddr_deser.sv
// Multi-lane DDR input deserialiser with shared word phase and bit-slip control.
module iddr_deser
    import iddr_deser_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int RATIO = 4
) (
    input  logic                   C,
    input  logic                   R_N,
    input  logic                   CE,
    input  logic [WIDTH-1:0]       D,
    input  logic                   BITSLIP,
    output logic [WIDTH*RATIO-1:0] Q,
    output logic                   Q_VALID,
    output logic                   SLIP_ACK
);

    localparam int HALF = RATIO / 2;
    localparam int PW   = clog2_min1(HALF + 1);
    localparam logic [PW-1:0] LAST_NORM = PW'(HALF - 1);
    localparam logic [PW-1:0] LAST_LONG = PW'(HALF);

    logic                        primed;
    logic                        stretch;
    logic                        odd;
    logic                        pending;
    logic                        wait_ack;
    logic [PW-1:0]               ph;
    logic                        shift;
    logic                        last;
    logic                        boundary;
    logic                        accept;
    logic [WIDTH-1:0][RATIO-1:0] q_lane;

    assign shift    = CE && primed;
    assign last     = (ph == (stretch ? LAST_LONG : LAST_NORM));
    assign boundary = shift && last;
    // A new slip is only taken once the previous one has been acknowledged.
    assign accept   = CE && BITSLIP && !pending && !wait_ack;

    // Word phase, slip sequencing and output strobes.
    always_ff @(posedge C or negedge R_N) begin
        if (!R_N) begin
            primed   <= 1'b0;
            stretch  <= 1'b0;
            odd      <= 1'b0;
            pending  <= 1'b0;
            wait_ack <= 1'b0;
            ph       <= '0;
            Q_VALID  <= 1'b0;
            SLIP_ACK <= 1'b0;
        end else begin
            Q_VALID  <= boundary;
            SLIP_ACK <= boundary && wait_ack;
            if (CE) primed <= 1'b1;
            if (shift) ph <= last ? '0 : ph + PW'(1);
            if (boundary) begin
                stretch  <= 1'b0;
                wait_ack <= pending;
                // The slip word itself keeps the old alignment; the next one moves.
                if (pending) begin
                    odd     <= ~odd;
                    pending <= 1'b0;
                    stretch <= ~odd;
                end
            end
            if (accept) pending <= 1'b1;
        end
    end

    for (genvar n = 0; n < WIDTH; n++) begin : g_lane
        iddr_deser_lane #(.RATIO(RATIO)) u_lane (
            .clk   (C),
            .rst_n (R_N),
            .ce    (CE),
            .d     (D[n]),
            .shift (shift),
            .load  (boundary),
            .odd   (odd),
            .q     (q_lane[n])
        );
    end

    assign Q = q_lane;

endmodule
